// File: rtl/riscv_pkg.sv
// Shared RISC-V constants: data width, load funct3 codes and the load
// extension helper used when returned load data enters the write-back buffer.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  // Select the addressed byte/half lane of the raw word and extend it.
  // Unrecognised funct3 codes pass the word through unchanged.
  function automatic logic [XLEN-1:0] load_extend(
    input logic [2:0]      funct3,
    input logic [1:0]      addr_lo,
    input logic [XLEN-1:0] word
  );
    logic [7:0]      byte_lane;
    logic [15:0]     half_lane;
    logic [XLEN-1:0] result;
    byte_lane = word[{addr_lo, 3'b000} +: 8];
    half_lane = addr_lo[1] ? word[31:16] : word[15:0];
    case (funct3)
      LB:      result = {{(XLEN-8){byte_lane[7]}}, byte_lane};
      LH:      result = {{(XLEN-16){half_lane[15]}}, half_lane};
      LBU:     result = {{(XLEN-8){1'b0}}, byte_lane};
      LHU:     result = {{(XLEN-16){1'b0}}, half_lane};
      LW:      result = word;
      default: result = word;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/wb_load_fifo.sv
// Synchronous FIFO holding returned loads as {rd, data} until the
// write-back arbiter pops them. Power-of-two depth so pointers wrap freely.
module wb_load_fifo #(
  parameter int DW    = riscv_pkg::XLEN + 5,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DW-1:0]            push_data,
  input  logic                     pop,
  output logic [DW-1:0]            pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage array; entries are don't-care while not counted, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy; a simultaneous push and pop leaves count alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: arbitrates between the ALU result and buffered load
// returns, registers the selected register-file write, and tracks which
// destination registers still have a load outstanding.
module wb_stage #(
  parameter int XLEN       = riscv_pkg::XLEN,
  parameter int FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            ld_issue,
  input  logic [4:0]      ld_issue_rd,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [4:0]      ld_rd,
  input  logic [XLEN-1:0] ld_data,
  input  logic [2:0]      ld_funct3,
  input  logic [1:0]      ld_addr_lo,
  output logic            RegWrite,
  output logic [4:0]      Rd,
  output logic [XLEN-1:0] Write_data,
  output logic [31:0]     pending
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CW-1:0]        fifo_count;
  logic [XLEN+4:0]      fifo_head;
  logic [XLEN+4:0]      fifo_in;
  logic                 enq;
  logic                 sel_ld;
  logic                 sel_alu;
  logic                 src_ld;
  logic [4:0]           head_rd;
  logic [XLEN-1:0]      head_data;
  logic [31:0]          pending_nxt;

  // Ready depends only on registered occupancy, never on this cycle's selection.
  assign ld_ready  = !fifo_full;
  assign alu_ready = !fifo_full;
  assign enq       = ld_valid && ld_ready;
  assign fifo_in   = {ld_rd, riscv_pkg::load_extend(ld_funct3, ld_addr_lo, ld_data)};
  assign head_rd   = fifo_head[XLEN+4:XLEN];
  assign head_data = fifo_head[XLEN-1:0];

  // Loads win when the buffer is full or the ALU is idle; otherwise the ALU goes.
  assign sel_ld  = !fifo_empty && (fifo_full || !alu_valid);
  assign sel_alu = !sel_ld && alu_valid && alu_ready;

  wb_load_fifo #(
    .DW    (XLEN + 5),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (enq),
    .push_data (fifo_in),
    .pop       (sel_ld),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Occupancy can never exceed the buffer depth.
  assert property (@(posedge clk) disable iff (!reset) fifo_count <= CW'(FIFO_DEPTH));

  // Register-file write port; rd=0 writes are consumed with RegWrite low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      RegWrite   <= 1'b0;
      Rd         <= '0;
      Write_data <= '0;
      src_ld     <= 1'b0;
    end else if (sel_ld) begin
      RegWrite   <= (head_rd != 5'd0);
      Rd         <= head_rd;
      Write_data <= head_data;
      src_ld     <= 1'b1;
    end else if (sel_alu) begin
      RegWrite   <= (alu_rd != 5'd0);
      Rd         <= alu_rd;
      Write_data <= alu_data;
      src_ld     <= 1'b0;
    end else begin
      RegWrite   <= 1'b0;
      src_ld     <= 1'b0;
    end
  end

  // Outstanding-load flags: clear on load commit, then set on issue so set wins.
  always_comb begin
    pending_nxt = pending;
    if (RegWrite && src_ld) pending_nxt[Rd] = 1'b0;
    if (ld_issue && (ld_issue_rd != 5'd0)) pending_nxt[ld_issue_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pending <= '0;
    else        pending <= pending_nxt;
  end

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: directed stimulus pushes expected writes,
// a negedge monitor pops and compares whenever RegWrite is high.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        ld_issue;
  logic [4:0]  ld_issue_rd;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_addr_lo;
  logic        RegWrite;
  logic [4:0]  Rd;
  logic [31:0] Write_data;
  logic [31:0] pending;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  wb_stage #(.XLEN(32), .FIFO_DEPTH(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .alu_ready   (alu_ready),
    .ld_issue    (ld_issue),
    .ld_issue_rd (ld_issue_rd),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_rd       (ld_rd),
    .ld_data     (ld_data),
    .ld_funct3   (ld_funct3),
    .ld_addr_lo  (ld_addr_lo),
    .RegWrite    (RegWrite),
    .Rd          (Rd),
    .Write_data  (Write_data),
    .pending     (pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_write(input logic [4:0] rd, input logic [31:0] data);
    exp_t e;
    e.rd   = rd;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic drive_load(input logic [4:0] rd, input logic [2:0] f3,
                            input logic [1:0] lo, input logic [31:0] data);
    ld_valid   = 1'b1;
    ld_rd      = rd;
    ld_funct3  = f3;
    ld_addr_lo = lo;
    ld_data    = data;
  endtask

  task automatic drive_alu(input logic [4:0] rd, input logic [31:0] data);
    alu_valid = 1'b1;
    alu_rd    = rd;
    alu_data  = data;
  endtask

  // Monitor: every write presented must match the head of the expected queue.
  always @(negedge clk) begin
    if (reset === 1'b1 && RegWrite === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got rd=%0d data=%h required no write", Rd, Write_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (Rd !== e.rd || Write_data !== e.data) begin
          errors++;
          $display("FAIL write: got rd=%0d data=%h required rd=%0d data=%h",
                   Rd, Write_data, e.rd, e.data);
        end
      end
    end
  end

  // Load vectors: rd, funct3, addr_lo, raw word, extended result.
  typedef struct {
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [1:0]  lo;
    logic [31:0] raw;
    logic [31:0] ext;
  } ldvec_t;

  ldvec_t ld_vecs[9] = '{
    '{5'd3,  3'b000, 2'd1, 32'h0000_8000, 32'hFFFF_FF80},
    '{5'd3,  3'b100, 2'd1, 32'h0000_8000, 32'h0000_0080},
    '{5'd3,  3'b001, 2'd0, 32'h0000_8000, 32'hFFFF_8000},
    '{5'd4,  3'b001, 2'd2, 32'h8001_7FFF, 32'hFFFF_8001},
    '{5'd4,  3'b101, 2'd2, 32'h8001_7FFF, 32'h0000_8001},
    '{5'd6,  3'b010, 2'd0, 32'hCAFE_F00D, 32'hCAFE_F00D},
    '{5'd6,  3'b000, 2'd3, 32'h7F00_0000, 32'h0000_007F},
    '{5'd8,  3'b100, 2'd2, 32'h00AB_0000, 32'h0000_00AB},
    '{5'd9,  3'b011, 2'd1, 32'h1122_3344, 32'h1122_3344}
  };

  initial begin
    reset       = 1'b0;
    alu_valid   = 1'b0;
    alu_rd      = '0;
    alu_data    = '0;
    ld_issue    = 1'b0;
    ld_issue_rd = '0;
    ld_valid    = 1'b0;
    ld_rd       = '0;
    ld_data     = '0;
    ld_funct3   = '0;
    ld_addr_lo  = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_regwrite", {31'd0, RegWrite}, 32'd0);
    check("rst_rd", {27'd0, Rd}, 32'd0);
    check("rst_wdata", Write_data, 32'd0);
    check("rst_pending", pending, 32'd0);
    check("rst_alu_ready", {31'd0, alu_ready}, 32'd1);
    check("rst_ld_ready", {31'd0, ld_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Plain ALU write, then idle cycle must hold Rd/Write_data.
    drive_alu(5'd5, 32'h1234_5678);
    expect_write(5'd5, 32'h1234_5678);
    tick();
    alu_valid = 1'b0;
    check("alu_regwrite", {31'd0, RegWrite}, 32'd1);
    tick();
    check("idle_regwrite", {31'd0, RegWrite}, 32'd0);
    check("idle_rd_hold", {27'd0, Rd}, 32'd5);
    check("idle_wdata_hold", Write_data, 32'h1234_5678);

    // Load extension vectors, back to back.
    foreach (ld_vecs[i]) begin
      drive_load(ld_vecs[i].rd, ld_vecs[i].f3, ld_vecs[i].lo, ld_vecs[i].raw);
      expect_write(ld_vecs[i].rd, ld_vecs[i].ext);
      tick();
    end
    ld_valid = 1'b0;
    repeat (3) tick();

    // Load buffered, then ALU arrives: ALU written first, load next.
    drive_load(5'd2, 3'b010, 2'd0, 32'h2222_2222);
    expect_write(5'd1, 32'h1111_1111);
    expect_write(5'd2, 32'h2222_2222);
    tick();
    ld_valid = 1'b0;
    drive_alu(5'd1, 32'h1111_1111);
    tick();
    alu_valid = 1'b0;
    repeat (3) tick();

    // Fill the buffer under a busy ALU; full stalls both sources.
    drive_alu(5'd9, 32'h0000_0009);
    drive_load(5'd10, 3'b010, 2'd0, 32'hA0A0_A0A0);
    expect_write(5'd9, 32'h0000_0009);
    tick();
    drive_alu(5'd12, 32'h0000_000C);
    drive_load(5'd11, 3'b010, 2'd0, 32'hB1B1_B1B1);
    expect_write(5'd12, 32'h0000_000C);
    tick();
    check("full_alu_ready", {31'd0, alu_ready}, 32'd0);
    check("full_ld_ready", {31'd0, ld_ready}, 32'd0);
    drive_alu(5'd13, 32'h0000_000D);
    drive_load(5'd14, 3'b010, 2'd0, 32'hE4E4_E4E4);
    expect_write(5'd10, 32'hA0A0_A0A0);
    expect_write(5'd13, 32'h0000_000D);
    expect_write(5'd11, 32'hB1B1_B1B1);
    expect_write(5'd14, 32'hE4E4_E4E4);
    tick();
    check("after_pop_alu_ready", {31'd0, alu_ready}, 32'd1);
    check("after_pop_ld_ready", {31'd0, ld_ready}, 32'd1);
    tick();
    alu_valid = 1'b0;
    ld_valid  = 1'b0;
    repeat (4) tick();

    // rd=0 ALU result is consumed silently.
    drive_alu(5'd0, 32'hDEAD_BEEF);
    check("rd0_alu_ready", {31'd0, alu_ready}, 32'd1);
    tick();
    alu_valid = 1'b0;
    check("rd0_regwrite", {31'd0, RegWrite}, 32'd0);
    tick();

    // Pending tracking for rd=7 through its commit edge.
    ld_issue    = 1'b1;
    ld_issue_rd = 5'd7;
    tick();
    ld_issue = 1'b0;
    check("pend_set", pending, 32'h0000_0080);
    drive_load(5'd7, 3'b010, 2'd0, 32'h0000_0077);
    expect_write(5'd7, 32'h0000_0077);
    tick();
    ld_valid = 1'b0;
    check("pend_after_enq", pending, 32'h0000_0080);
    tick();
    check("pend_during_write", pending, 32'h0000_0080);
    tick();
    check("pend_cleared", pending, 32'h0000_0000);

    // Issue of rd=0 never sets pending[0].
    ld_issue    = 1'b1;
    ld_issue_rd = 5'd0;
    tick();
    ld_issue = 1'b0;
    check("pend_rd0", pending, 32'h0000_0000);

    // Same-edge clear and set of rd=7: set wins.
    ld_issue    = 1'b1;
    ld_issue_rd = 5'd7;
    tick();
    ld_issue = 1'b0;
    drive_load(5'd7, 3'b010, 2'd0, 32'h0000_0707);
    expect_write(5'd7, 32'h0000_0707);
    tick();
    ld_valid = 1'b0;
    tick();
    ld_issue    = 1'b1;
    ld_issue_rd = 5'd7;
    tick();
    ld_issue = 1'b0;
    check("pend_set_wins", pending, 32'h0000_0080);

    // Reset mid-operation with pending[7] set and a load buffered.
    drive_load(5'd8, 3'b010, 2'd0, 32'h8888_8888);
    tick();
    ld_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("midrst_pending", pending, 32'h0000_0000);
    check("midrst_regwrite", {31'd0, RegWrite}, 32'd0);
    check("midrst_alu_ready", {31'd0, alu_ready}, 32'd1);
    check("midrst_ld_ready", {31'd0, ld_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) tick();
    check("post_rst_regwrite", {31'd0, RegWrite}, 32'd0);

    // Normal operation resumes after reset.
    drive_alu(5'd31, 32'h0BAD_F00D);
    expect_write(5'd31, 32'h0BAD_F00D);
    tick();
    alu_valid = 1'b0;
    repeat (3) tick();

    check("queue_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish required finish before 200000");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

endmodule
